jk_reg_bank: RTL and testbench
==============================

Name: jk_reg_bank

Overview:
- Parametrised WIDTH-bit register bank in which every bit is a JK flip-flop cell.
- Adds clock enable, synchronous active-low reset, parallel load and four operating modes:
  - independent per-bit JK
  - synchronous up counter
  - synchronous down counter
  - serial shift register
- All modes are built from JK toggle, set and reset actions.
- General-purpose storage and counting primitive for the behavioural-design library.

Parameters:
- WIDTH, 4, number of bits. Must be at least 2.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q on reset.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- en  input  1  clock enable for mode operation.
- mode  input  2  operating mode: 0 JK, 1 UP, 2 DOWN, 3 SHIFT.
- j  input  WIDTH  per-bit J inputs (JK mode only).
- k  input  WIDTH  per-bit K inputs (JK mode only).
- load  input  1  parallel load strobe.
- load_val  input  WIDTH  parallel load data.
- ser_in  input  1  serial data in (SHIFT mode).
- q  output  WIDTH  registered state.
- qb  output  WIDTH  registered complement; always equal to ~q.
- ser_out  output  1  q[WIDTH-1].
- tc  output  1  terminal count.

Behaviour:
- One clock (clk). Reset is synchronous and active-low (rst_n).
- Priority at each rising edge: rst_n=0, then load=1, then en=1, then hold.
- Reset: q=RESET_VAL and qb=~RESET_VAL at the edge. ser_out and tc follow from the reset q.
  - Reset has effect only at an edge.
  - Reset mid-count or mid-shift discards the operation in progress with no residue.
- Load: q=load_val and qb=~load_val. Load is independent of en and mode.
- en=0 with no load or reset: q and qb hold.
- Latency: q updates at the edge following input setup; one cycle.
- JK mode, per bit i, using {j[i],k[i]}:
  - 00 hold
  - 01 clear to 0
  - 10 set to 1
  - 11 toggle
- UP mode:
  - bit 0 always toggles.
  - bit i toggles iff q[i-1:0] are all 1.
  - All-ones wraps to all-zeros.
- DOWN mode:
  - bit 0 always toggles.
  - bit i toggles iff q[i-1:0] are all 0.
  - All-zeros wraps to all-ones.
- SHIFT mode:
  - q <= {q[WIDTH-2:0], ser_in}.
  - ser_out = q[WIDTH-1], combinational from the register.
- tc, combinational decode of registered q and current mode:
  - 1 when mode=UP and q is all-ones.
  - 1 when mode=DOWN and q is all-zeros.
  - 0 in JK and SHIFT modes.
  - tc is independent of en.
- Mode change:
  - Takes effect at the next edge; q is preserved across the change.
  - tc re-decodes immediately when mode changes.
- j and k are ignored outside JK mode. ser_in is ignored outside SHIFT mode.
- No X propagation from unused inputs.

Decomposition:
- Package jk_pkg:
  - mode constants MODE_JK=2'd0, MODE_UP=2'd1, MODE_DOWN=2'd2, MODE_SHIFT=2'd3.
  - JK action codes JK_HOLD=2'b00, JK_CLR=2'b01, JK_SET=2'b10, JK_TOG=2'b11.
- Sub-module jk_cell:
  - One-bit JK flip-flop with ports clk, rst_n, rst_val, j, k, q, qb.
  - Synchronous active-low reset to rst_val.
  - Instantiated WIDTH times.
- Top level computes the effective per-bit J/K pair:
  - load: J=load_val[i], K=~load_val[i].
  - JK mode with en: pass j/k through.
  - UP/DOWN with en: J=K=toggle condition.
  - SHIFT with en: J=src, K=~src.
  - otherwise: J=K=0.

Test Plan:
- Reset, WIDTH=4, RESET_VAL=4'hA: rst_n=0 for one edge with load=1 and en=1 -> q=1010, qb=0101.
- JK mode from q=0000, j=1100, k=1010, en=1:
  - edge 1 -> q=1100 (bit3 toggle, bit2 set, bit1 clear, bit0 hold).
  - edge 2 -> q=0100.
- UP from load_val=1110:
  - edge 1 -> q=1111, tc=1.
  - edge 2 -> q=0000, tc=0 (wrap).
  - en=0 for 3 edges -> q holds 0000.
- DOWN from q=0001:
  - edge 1 -> q=0000, tc=1.
  - edge 2 -> q=1111, tc=0.
  - switching mode to UP with q=1111 -> tc=1 with no clock edge.
- SHIFT from q=0000, ser_in sequence 1,0,1,1 -> q=0001, 0010, 0101, 1011; ser_out=1 after the fourth edge.
- Priority: mode UP, en=1, load=1, load_val=0110 -> q=0110 (no increment). Then rst_n=0 with load=1 -> q=RESET_VAL.

Source files
------------

// File: rtl/jk_pkg.sv
// Shared constants for the JK register bank:
// operating modes and per-bit JK action codes.
package jk_pkg;

  localparam logic [1:0] MODE_JK    = 2'd0;
  localparam logic [1:0] MODE_UP    = 2'd1;
  localparam logic [1:0] MODE_DOWN  = 2'd2;
  localparam logic [1:0] MODE_SHIFT = 2'd3;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TOG  = 2'b11;

endpackage

// File: rtl/jk_reg_bank_if.sv
// Control/data bundle between a host and the
// JK register bank.
interface jk_reg_bank_if #(
  parameter int WIDTH = 4
);

  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             ser_in;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qb;
  logic             ser_out;
  logic             tc;

  modport master (
    output en, mode, j, k,
    output load, load_val, ser_in,
    input  q, qb, ser_out, tc
  );

  modport slave (
    input  en, mode, j, k,
    input  load, load_val, ser_in,
    output q, qb, ser_out, tc
  );

endinterface

// File: rtl/jk_cell.sv
// One-bit JK flip-flop with synchronous
// active-low reset to a per-cell value.
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic rst_val,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qb
);

  logic q_d;
  logic q_q;

  always_comb begin
    q_d = q_q;
    unique case ({j, k})
      JK_HOLD: q_d = q_q;
      JK_CLR:  q_d = 1'b0;
      JK_SET:  q_d = 1'b1;
      JK_TOG:  q_d = ~q_q;
      default: q_d = q_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) q_q <= rst_val;
    else        q_q <= q_d;
  end

  assign q  = q_q;
  assign qb = ~q_q;

endmodule

// File: rtl/jk_reg_bank.sv
// WIDTH-bit bank of JK cells with load,
// JK, up/down count and shift modes.
module jk_reg_bank
  import jk_pkg::*;
#(
  parameter int             WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic          clk,
  input  logic          rst_n,
  jk_reg_bank_if.slave  bus
);

  logic [WIDTH-1:0] q_w;
  logic [WIDTH-1:0] qb_w;
  logic [WIDTH-1:0] tog_up;
  logic [WIDTH-1:0] tog_dn;
  logic [WIDTH-1:0] shift_src;
  logic [WIDTH-1:0] j_eff;
  logic [WIDTH-1:0] k_eff;
  logic             all1;
  logic             all0;

  // Ripple prefix: bit i toggles when all lower bits are 1 (up) / 0 (down)
  always_comb begin
    tog_up = '0;
    tog_dn = '0;
    all1   = 1'b1;
    all0   = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      tog_up[i] = all1;
      tog_dn[i] = all0;
      all1      = all1 & q_w[i];
      all0      = all0 & ~q_w[i];
    end
  end

  assign shift_src = {q_w[WIDTH-2:0], bus.ser_in};

  always_comb begin
    j_eff = '0;
    k_eff = '0;
    unique case (1'b1)
      bus.load: begin
        j_eff = bus.load_val;
        k_eff = ~bus.load_val;
      end
      (!bus.load && bus.en && bus.mode == MODE_JK): begin
        j_eff = bus.j;
        k_eff = bus.k;
      end
      (!bus.load && bus.en && bus.mode == MODE_UP): begin
        j_eff = tog_up;
        k_eff = tog_up;
      end
      (!bus.load && bus.en && bus.mode == MODE_DOWN): begin
        j_eff = tog_dn;
        k_eff = tog_dn;
      end
      (!bus.load && bus.en && bus.mode == MODE_SHIFT): begin
        j_eff = shift_src;
        k_eff = ~shift_src;
      end
      default: begin
        j_eff = '0;
        k_eff = '0;
      end
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .rst_val (RESET_VAL[i]),
      .j       (j_eff[i]),
      .k       (k_eff[i]),
      .q       (q_w[i]),
      .qb      (qb_w[i])
    );
  end

  assign bus.q       = q_w;
  assign bus.qb      = qb_w;
  assign bus.ser_out = q_w[WIDTH-1];
  assign bus.tc      = (bus.mode == MODE_UP   && all1)
                    || (bus.mode == MODE_DOWN && all0);

endmodule

// File: tb/tb_jk_reg_bank.sv
// Directed bench for jk_reg_bank with
// WIDTH=4 and RESET_VAL=4'hA.
module tb_jk_reg_bank;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  jk_reg_bank_if #(.WIDTH(4)) bus ();

  jk_reg_bank #(
    .WIDTH     (4),
    .RESET_VAL (4'hA)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] v);
    bus.load     = 1'b1;
    bus.load_val = v;
    tick();
    bus.load     = 1'b0;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.load     = 1'b1;
    bus.load_val = 4'b0101;
    bus.en       = 1'b1;
    bus.mode     = 2'd0;
    tick();
    rst_n    = 1'b1;
    bus.load = 1'b0;
    bus.en   = 1'b0;
    n_tests++;
    if (bus.q !== 4'b1010) begin
      n_fail++;
      $display("FAIL reset_q got %b want 1010", bus.q);
    end
    n_tests++;
    if (bus.qb !== 4'b0101) begin
      n_fail++;
      $display("FAIL reset_qb got %b want 0101", bus.qb);
    end
    n_tests++;
    if (bus.ser_out !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ser_out got %b want 1", bus.ser_out);
    end
    n_tests++;
    if (bus.tc !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_tc got %b want 0", bus.tc);
    end
  endtask

  task automatic test_jk();
    bus.mode = 2'd0;
    do_load(4'b0000);
    bus.en = 1'b1;
    bus.j  = 4'b1100;
    bus.k  = 4'b1010;
    tick();
    n_tests++;
    if (bus.q !== 4'b1100) begin
      n_fail++;
      $display("FAIL jk_edge1 got %b want 1100", bus.q);
    end
    n_tests++;
    if (bus.qb !== 4'b0011) begin
      n_fail++;
      $display("FAIL jk_qb got %b want 0011", bus.qb);
    end
    tick();
    n_tests++;
    if (bus.q !== 4'b0100) begin
      n_fail++;
      $display("FAIL jk_edge2 got %b want 0100", bus.q);
    end
    n_tests++;
    if (bus.tc !== 1'b0) begin
      n_fail++;
      $display("FAIL jk_tc got %b want 0", bus.tc);
    end
    bus.en = 1'b0;
  endtask

  task automatic test_up();
    bus.mode = 2'd1;
    bus.j    = 4'b1111;
    bus.k    = 4'b0000;
    do_load(4'b1110);
    n_tests++;
    if (bus.q !== 4'b1110 || bus.tc !== 1'b0) begin
      n_fail++;
      $display("FAIL up_load got q=%b tc=%b want 1110/0", bus.q, bus.tc);
    end
    bus.en = 1'b1;
    tick();
    n_tests++;
    if (bus.q !== 4'b1111 || bus.tc !== 1'b1) begin
      n_fail++;
      $display("FAIL up_edge1 got q=%b tc=%b want 1111/1", bus.q, bus.tc);
    end
    tick();
    n_tests++;
    if (bus.q !== 4'b0000 || bus.tc !== 1'b0) begin
      n_fail++;
      $display("FAIL up_wrap got q=%b tc=%b want 0000/0", bus.q, bus.tc);
    end
    bus.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (bus.q !== 4'b0000) begin
        n_fail++;
        $display("FAIL up_hold%0d got %b want 0000", i, bus.q);
      end
    end
    bus.en = 1'b1;
    tick();
    n_tests++;
    if (bus.q !== 4'b0001) begin
      n_fail++;
      $display("FAIL up_resume got %b want 0001", bus.q);
    end
    bus.en = 1'b0;
  endtask

  task automatic test_down();
    bus.mode = 2'd2;
    do_load(4'b0001);
    bus.en = 1'b1;
    tick();
    n_tests++;
    if (bus.q !== 4'b0000 || bus.tc !== 1'b1) begin
      n_fail++;
      $display("FAIL dn_edge1 got q=%b tc=%b want 0000/1", bus.q, bus.tc);
    end
    tick();
    n_tests++;
    if (bus.q !== 4'b1111 || bus.tc !== 1'b0) begin
      n_fail++;
      $display("FAIL dn_wrap got q=%b tc=%b want 1111/0", bus.q, bus.tc);
    end
    tick();
    n_tests++;
    if (bus.q !== 4'b1110) begin
      n_fail++;
      $display("FAIL dn_edge3 got %b want 1110", bus.q);
    end
    do_load(4'b1111);
    bus.en = 1'b0;
    bus.mode = 2'd1;
    #1;
    n_tests++;
    if (bus.tc !== 1'b1) begin
      n_fail++;
      $display("FAIL mode_tc_up got %b want 1", bus.tc);
    end
    bus.mode = 2'd3;
    #1;
    n_tests++;
    if (bus.tc !== 1'b0) begin
      n_fail++;
      $display("FAIL mode_tc_shift got %b want 0", bus.tc);
    end
    bus.mode = 2'd0;
    #1;
    n_tests++;
    if (bus.tc !== 1'b0 || bus.q !== 4'b1111) begin
      n_fail++;
      $display("FAIL mode_tc_jk got tc=%b q=%b want 0/1111", bus.tc, bus.q);
    end
  endtask

  task automatic test_shift();
    logic [3:0] bits;
    logic [3:0] exp [4];
    bits   = 4'b1011;
    exp[0] = 4'b0001;
    exp[1] = 4'b0010;
    exp[2] = 4'b0101;
    exp[3] = 4'b1011;
    bus.mode = 2'd3;
    bus.j    = 4'b1111;
    bus.k    = 4'b1111;
    do_load(4'b0000);
    bus.en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.ser_in = bits[3-i];
      tick();
      n_tests++;
      if (bus.q !== exp[i]) begin
        n_fail++;
        $display("FAIL shift%0d got %b want %b", i, bus.q, exp[i]);
      end
    end
    n_tests++;
    if (bus.ser_out !== 1'b1) begin
      n_fail++;
      $display("FAIL shift_ser_out got %b want 1", bus.ser_out);
    end
    bus.en = 1'b0;
    bus.ser_in = 1'b0;
  endtask

  task automatic test_priority();
    bus.mode     = 2'd1;
    bus.en       = 1'b1;
    bus.load     = 1'b1;
    bus.load_val = 4'b0110;
    tick();
    n_tests++;
    if (bus.q !== 4'b0110) begin
      n_fail++;
      $display("FAIL prio_load got %b want 0110", bus.q);
    end
    rst_n = 1'b0;
    tick();
    rst_n    = 1'b1;
    bus.load = 1'b0;
    n_tests++;
    if (bus.q !== 4'b1010 || bus.qb !== 4'b0101) begin
      n_fail++;
      $display("FAIL prio_reset got q=%b qb=%b want 1010/0101", bus.q, bus.qb);
    end
    tick();
    n_tests++;
    if (bus.q !== 4'b1011) begin
      n_fail++;
      $display("FAIL post_reset_up got %b want 1011", bus.q);
    end
    bus.en = 1'b0;
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    rst_n        = 1'b1;
    bus.en       = 1'b0;
    bus.mode     = 2'd0;
    bus.j        = '0;
    bus.k        = '0;
    bus.load     = 1'b0;
    bus.load_val = '0;
    bus.ser_in   = 1'b0;
    test_reset();
    test_jk();
    test_up();
    test_down();
    test_shift();
    test_priority();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
